// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared arbiter encodings and cache block geometry (package arb_pkg)
package arb_pkg;

    localparam int BLK_WORDS = 8;
    localparam int BLK_IDX_W = $clog2(BLK_WORDS);
    localparam int BLK_OFF_W = BLK_IDX_W + 1;
    localparam int MEM_LAT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache request, memory and fill-return signals of the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              fill_valid;
    logic              fill_dst;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              i_done;
    logic              d_done;
    logic              busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_dst, fill_idx,
               fill_data, i_done, d_done, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_dst, fill_idx,
               fill_data, i_done, d_done, busy
    );
endinterface

// File: rtl/mem_arbiter_fill_sequencer.sv
// rtl/mem_arbiter_fill_sequencer.sv - block fill issue/return counters and word address generation
module fill_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8,
    localparam int IDX_W      = $clog2(BLOCK_WORDS),
    localparam int OFF_W      = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    active,
    input  logic [ADDR_W-1:OFF_W]   blk_addr,
    input  logic                    mem_valid,
    output logic                    issue_en,
    output logic [ADDR_W-1:0]       issue_addr,
    output logic                    ret_valid,
    output logic [IDX_W-1:0]        ret_idx,
    output logic                    last
);

    logic [IDX_W-1:0] issue_cnt_q, issue_cnt_d;
    logic             issue_done_q, issue_done_d;
    logic [IDX_W-1:0] ret_cnt_q, ret_cnt_d;

    assign issue_en   = active & ~issue_done_q;
    assign issue_addr = {blk_addr, issue_cnt_q, 1'b0};
    assign ret_valid  = active & mem_valid;
    assign ret_idx    = ret_cnt_q;
    assign last       = ret_valid & (ret_cnt_q == IDX_W'(BLOCK_WORDS - 1));

    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        issue_done_d = issue_done_q;
        ret_cnt_d    = ret_cnt_q;
        if (start) begin
            issue_cnt_d  = '0;
            issue_done_d = 1'b0;
            ret_cnt_d    = '0;
        end else begin
            // Issue stops after the last word so a slow memory never sees extra reads.
            if (issue_en) begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == IDX_W'(BLOCK_WORDS - 1)) begin
                    issue_done_d = 1'b1;
                end
            end
            if (ret_valid) begin
                ret_cnt_d = ret_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q  <= '0;
            issue_done_q <= 1'b0;
            ret_cnt_q    <= '0;
        end else begin
            issue_cnt_q  <= issue_cnt_d;
            issue_done_q <= issue_done_d;
            ret_cnt_q    <= ret_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache main-memory arbiter; ARB_ROUND_ROBIN_EN selects round-robin contests
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = arb_pkg::BLK_WORDS,
    localparam int IDX_W      = $clog2(BLOCK_WORDS),
    localparam int OFF_W      = IDX_W + 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic              dst_q, dst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              prio_d;
    logic              pick_d;
    logic              start_fill;

    logic              seq_issue_en;
    logic [ADDR_W-1:0] seq_issue_addr;
    logic              seq_ret_valid;
    logic [IDX_W-1:0]  seq_ret_idx;
    logic              seq_last;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign prio_d = (last_q == REQ_I);
`else
    assign prio_d = 1'b1;
`endif

    assign pick_d = bus.d_req & (~bus.i_req | prio_d);

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        start_fill = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.d_req | bus.i_req) begin
                    dst_d   = pick_d ? REQ_D : REQ_I;
                    addr_d  = pick_d ? bus.d_addr : bus.i_addr;
                    wdata_d = bus.d_wdata;
                    if (pick_d & bus.d_we) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d    = ST_FILL;
                        start_fill = 1'b1;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    // Only real contests move the round-robin pointer.
                    if (bus.i_req & bus.d_req) begin
                        last_d = pick_d ? REQ_D : REQ_I;
                    end
`endif
                end
            end
            ST_FILL: begin
                if (seq_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dst_q   <= REQ_I;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= REQ_I;
`endif
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    fill_sequencer #(
        .ADDR_W      (ADDR_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_fill_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start_fill),
        .active     (state_q == ST_FILL),
        .blk_addr   (addr_q[ADDR_W-1:OFF_W]),
        .mem_valid  (bus.mem_valid),
        .issue_en   (seq_issue_en),
        .issue_addr (seq_issue_addr),
        .ret_valid  (seq_ret_valid),
        .ret_idx    (seq_ret_idx),
        .last       (seq_last)
    );

    // Outputs are forced to zero whenever they carry no meaning so idle cycles are clean.
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.mem_en     = (state_q == ST_WRITE) | seq_issue_en;
    assign bus.mem_wr     = (state_q == ST_WRITE);
    assign bus.mem_addr   = (state_q == ST_WRITE) ? addr_q :
                            seq_issue_en          ? seq_issue_addr : '0;
    assign bus.mem_wdata  = (state_q == ST_WRITE) ? wdata_q : '0;
    assign bus.fill_valid = seq_ret_valid;
    assign bus.fill_dst   = (state_q == ST_FILL) & dst_q;
    assign bus.fill_idx   = seq_ret_valid ? seq_ret_idx : '0;
    assign bus.fill_data  = seq_ret_valid ? bus.mem_rdata : '0;
    assign bus.i_done     = seq_last & (dst_q == REQ_I);
    assign bus.d_done     = (seq_last & (dst_q == REQ_D)) | (state_q == ST_WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BW = 8;

    typedef struct packed {
        logic        dst;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        done;
    } fill_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(3)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rd_count, first_rd_cyc, last_rd_cyc;
    logic spur = 1'b0;
    logic rr_last_d = 1'b0;

    logic [15:0] exp_rd_q[$];
    fill_t       exp_fill_q[$];
    wr_t         exp_wr_q[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // memory model: a read accepted in cycle c returns in cycle c+MEM_LAT
    logic        pv[MEM_LAT];
    logic [15:0] pa[MEM_LAT];
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= bus.mem_en & ~bus.mem_wr;
            pa[0] <= bus.mem_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end
    assign bus.mem_valid = (pv[MEM_LAT-1] === 1'b1) | spur;
    assign bus.mem_rdata = (pv[MEM_LAT-1] === 1'b1) ? mem_word(pa[MEM_LAT-1]) : 16'hDEAD;

    logic [15:0] mon_e;
    fill_t       mon_f;
    wr_t         mon_w;
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0) begin
            if (rd_count == 0) first_rd_cyc = cyc;
            rd_count++;
            last_rd_cyc = cyc;
            vectors++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected addr=%h", bus.mem_addr);
            end else begin
                mon_e = exp_rd_q.pop_front();
                if (bus.mem_addr !== mon_e) begin
                    errors++;
                    $display("FAIL rd_addr got=%h exp=%h", bus.mem_addr, mon_e);
                end
            end
        end
        if (bus.mem_wr === 1'b1) begin
            vectors++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected addr=%h", bus.mem_addr);
            end else begin
                mon_w = exp_wr_q.pop_front();
                if ({bus.mem_en, bus.mem_addr, bus.mem_wdata, bus.d_done, bus.fill_valid} !==
                    {1'b1, mon_w.a, mon_w.d, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL wr_cycle got en=%b a=%h d=%h done=%b fv=%b exp a=%h d=%h",
                             bus.mem_en, bus.mem_addr, bus.mem_wdata, bus.d_done,
                             bus.fill_valid, mon_w.a, mon_w.d);
                end
            end
        end
        if (bus.fill_valid === 1'b1) begin
            vectors++;
            if (exp_fill_q.size() == 0) begin
                errors++;
                $display("FAIL fill_unexpected idx=%0d data=%h", bus.fill_idx, bus.fill_data);
            end else begin
                mon_f = exp_fill_q.pop_front();
                if ({bus.fill_dst, bus.fill_idx, bus.fill_data, bus.i_done, bus.d_done} !==
                    {mon_f.dst, mon_f.idx, mon_f.data,
                     mon_f.done & ~mon_f.dst, mon_f.done & mon_f.dst}) begin
                    errors++;
                    $display("FAIL fill got dst=%b idx=%0d data=%h id=%b dd=%b exp dst=%b idx=%0d data=%h done=%b",
                             bus.fill_dst, bus.fill_idx, bus.fill_data, bus.i_done, bus.d_done,
                             mon_f.dst, mon_f.idx, mon_f.data, mon_f.done);
                end
            end
        end else if (bus.mem_wr !== 1'b1 && (bus.i_done === 1'b1 || bus.d_done === 1'b1)) begin
            errors++;
            $display("FAIL done_stray i_done=%b d_done=%b", bus.i_done, bus.d_done);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_fill(input logic dst, input logic [15:0] addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < BW; k++) begin
            exp_rd_q.push_back(base + 16'(2 * k));
            exp_fill_q.push_back('{dst, 3'(k), mem_word(base + 16'(2 * k)), (k == BW - 1)});
        end
    endtask

    task automatic wait_done(input logic want_d, input string name);
        bit seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            tick();
            if ((want_d ? bus.d_done : bus.i_done) === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got=0 exp=done", name);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_rd_q.size() != 0 || exp_fill_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got rd=%0d fill=%0d wr=%0d exp=0", name,
                     exp_rd_q.size(), exp_fill_q.size(), exp_wr_q.size());
        end
    endtask

    task automatic check_quiet(input string name);
        vectors++;
        if ({bus.busy, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_valid,
             bus.fill_dst, bus.fill_idx, bus.fill_data, bus.i_done, bus.d_done} !== '0) begin
            errors++;
            $display("FAIL %s_outputs got busy=%b en=%b wr=%b a=%h fv=%b id=%b dd=%b exp=all0",
                     name, bus.busy, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.fill_valid,
                     bus.i_done, bus.d_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b0;
        tick();
        check_quiet("post_reset");
    endtask

    task automatic test_i_fill();
        rd_count = 0;
        push_fill(REQ_I, 16'h0046);
        bus.i_addr = 16'h0046;
        bus.i_req  = 1'b1;
        wait_done(REQ_I, "i_fill");
        bus.i_req = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL i_fill_busy got=%b exp=0", bus.busy);
        end
        vectors++;
        if (rd_count != BW || last_rd_cyc - first_rd_cyc != BW - 1) begin
            errors++;
            $display("FAIL i_fill_issue got n=%0d span=%0d exp n=8 span=7",
                     rd_count, last_rd_cyc - first_rd_cyc);
        end
        check_drained("i_fill");
    endtask

    task automatic test_contest(input logic [15:0] ia, input logic [15:0] da);
        logic d_first;
        bit   got_first = 0, gap_pending = 0, i_seen = 0, d_seen = 0;
`ifdef ARB_ROUND_ROBIN_EN
        d_first   = ~rr_last_d;
        rr_last_d = d_first;
`else
        d_first = 1'b1;
`endif
        if (d_first) begin
            push_fill(REQ_D, da);
            push_fill(REQ_I, ia);
        end else begin
            push_fill(REQ_I, ia);
            push_fill(REQ_D, da);
        end
        bus.i_addr = ia;
        bus.d_addr = da;
        bus.d_we   = 1'b0;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        for (int t = 0; t < 200 && !(i_seen && d_seen && !gap_pending); t++) begin
            tick();
            if (gap_pending) begin
                gap_pending = 0;
                vectors++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL contest_gap got busy=%b exp=0", bus.busy);
                end
            end
            if (bus.d_done === 1'b1 || bus.i_done === 1'b1) begin
                if (!got_first) begin
                    got_first   = 1;
                    gap_pending = 1;
                    vectors++;
                    if (bus.d_done !== d_first) begin
                        errors++;
                        $display("FAIL contest_order got d_first=%b exp=%b", bus.d_done, d_first);
                    end
                end
                if (bus.d_done === 1'b1) begin
                    d_seen = 1;
                    bus.d_req = 1'b0;
                end
                if (bus.i_done === 1'b1) begin
                    i_seen = 1;
                    bus.i_req = 1'b0;
                end
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        vectors++;
        if (!(i_seen && d_seen)) begin
            errors++;
            $display("FAIL contest_timeout got i=%0d d=%0d exp=1 1", i_seen, d_seen);
        end
        tick();
        check_drained("contest");
    endtask

    task automatic test_write();
        exp_wr_q.push_back('{16'h2002, 16'hBEEF});
        bus.d_addr  = 16'h2002;
        bus.d_wdata = 16'hBEEF;
        bus.d_we    = 1'b1;
        bus.d_req   = 1'b1;
        wait_done(REQ_D, "write");
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
        check_quiet("write_after");
        check_drained("write");
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        push_fill(REQ_I, 16'h0500);
        bus.i_addr = 16'h0500;
        bus.i_req  = 1'b1;
        for (int t = 0; t < 100 && !hit; t++) begin
            tick();
            if (bus.fill_valid === 1'b1 && bus.fill_idx === 3'd2) hit = 1;
        end
        vectors++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_timeout got=0 exp=word2");
        end
        rst = 1'b1;
        bus.i_req = 1'b0;
        tick();
        check_quiet("rst_mid");
        exp_rd_q.delete();
        exp_fill_q.delete();
        rr_last_d = 1'b0;
        rst = 1'b0;
        repeat (4) tick();
        check_quiet("rst_mid_idle");
        rd_count = 0;
        push_fill(REQ_I, 16'h0512);
        bus.i_addr = 16'h0512;
        bus.i_req  = 1'b1;
        wait_done(REQ_I, "rst_restart");
        bus.i_req = 1'b0;
        tick();
        check_drained("rst_restart");
    endtask

    task automatic test_spurious();
        bit started = 0;
        spur = 1'b1;
        tick();
        vectors++;
        if ({bus.fill_valid, bus.busy, bus.i_done, bus.d_done} !== 4'b0) begin
            errors++;
            $display("FAIL spur_idle got fv=%b busy=%b exp=0", bus.fill_valid, bus.busy);
        end
        tick();
        spur = 1'b0;
        push_fill(REQ_I, 16'h0746);
        bus.i_addr = 16'h0746;
        bus.i_req  = 1'b1;
        for (int t = 0; t < 20 && !started; t++) begin
            tick();
            if (bus.mem_en === 1'b1) started = 1;
        end
        bus.i_addr = 16'hFFFF;
        wait_done(REQ_I, "spur_fill");
        bus.i_req = 1'b0;
        tick();
        check_drained("spur_fill");
    endtask

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        rd_count    = 0;
        test_reset();
        test_i_fill();
        test_contest(16'h0100, 16'h1230);
        test_contest(16'h0306, 16'h244A);
        test_write();
        test_reset_mid();
        test_spurious();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
